// File: rtl/adc_bcd_front_pkg.sv
// Shared definitions for the ADC0804 -> BCD front end: FSM states, widths, digit packing.
package adc_bcd_front_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StRead,
        StScale,
        StConv,
        StUpdate
    } state_e;

    localparam int unsigned BinW   = 14;   // binary operand width fed to the converter
    localparam int unsigned BcdW   = 16;   // four packed BCD digits
    localparam int unsigned BcdMax = 9999; // largest value four digits can show

    // The converter yields thousands in the top nibble; the display port wants
    // thousands in the bottom nibble (first digit shown) and units in the top.
    function automatic logic [BcdW-1:0] pack_digits(input logic [BcdW-1:0] natural);
        return {natural[3:0], natural[7:4], natural[11:8], natural[15:12]};
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, BinW iterations in total.
// The load cycle already performs the first iteration, so the result is stable (done=1)
// exactly BinW cycles after start.
module bcd_dabble_seq
    import adc_bcd_front_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BinW-1:0] bin,
    output logic            done,
    output logic [BcdW-1:0] bcd
);

    localparam int unsigned ShW   = BcdW + BinW;
    localparam int unsigned IterW = $clog2(BinW + 1);

    logic [ShW-1:0]   shift_q, shift_d;
    logic [IterW-1:0] iter_q, iter_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    // One iteration: add 3 to every BCD nibble >= 5, then shift the whole register left.
    function automatic logic [ShW-1:0] dabble_step(input logic [ShW-1:0] v);
        logic [ShW-1:0] a;
        a = v;
        for (int d = 0; d < BcdW / 4; d++) begin
            if (a[BinW + 4*d +: 4] >= 4'd5) begin
                a[BinW + 4*d +: 4] = a[BinW + 4*d +: 4] + 4'd3;
            end
        end
        return {a[ShW-2:0], 1'b0};
    endfunction

    // Next-state: load on start, then iterate until the last iteration is done.
    always_comb begin
        shift_d = shift_q;
        iter_d  = iter_q;
        run_d   = run_q;
        done_d  = 1'b0;
        if (start) begin
            shift_d = dabble_step({{BcdW{1'b0}}, bin});
            iter_d  = IterW'(1);
            run_d   = 1'b1;
        end else if (run_q) begin
            shift_d = dabble_step(shift_q);
            iter_d  = iter_q + IterW'(1);
            if (iter_q == IterW'(BinW - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            iter_q  <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            iter_q  <= iter_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = shift_q[ShW-1 -: BcdW];

endmodule

// File: rtl/adc_bcd_front.sv
// ADC0804 handshake, sample scaling/clamping and BCD conversion for the LM35 display path.
module adc_bcd_front
    import adc_bcd_front_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned WR_PULSE      = 8,
    parameter int unsigned RD_PULSE      = 8,
    parameter int unsigned INTR_TIMEOUT  = 20000,
    parameter int unsigned SCALE_MUL     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      adc_data,
    input  logic            adc_intr_n,
    output logic            adc_cs_n,
    output logic            adc_wr_n,
    output logic            adc_rd_n,
    output logic [BcdW-1:0] bcd,
    output logic            busy,
    output logic            valid,
    output logic            timeout_err
);

    localparam int unsigned PeriodW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned StepA   = (INTR_TIMEOUT > WR_PULSE) ? INTR_TIMEOUT : WR_PULSE;
    localparam int unsigned StepMax = (StepA > RD_PULSE) ? StepA : RD_PULSE;
    localparam int unsigned StepW   = $clog2(StepMax + 1);

    state_e             state_q, state_d;
    logic [PeriodW-1:0] period_q, period_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [7:0]         sample_q, sample_d;
    logic [BcdW-1:0]    bcd_q, bcd_d;
    logic               timeout_q, timeout_d;
    logic               intr_meta_q, intr_sync_q;
    logic               cs_n_q, wr_n_q, rd_n_q, busy_q, valid_q;

    logic [31:0]        product;
    logic [BinW-1:0]    scaled;
    logic               dab_start;
    logic               dab_done;
    logic [BcdW-1:0]    dab_bcd;

    // Two-stage synchroniser for the asynchronous end-of-conversion strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intr_meta_q <= 1'b1;
            intr_sync_q <= 1'b1;
        end else begin
            intr_meta_q <= adc_intr_n;
            intr_sync_q <= intr_meta_q;
        end
    end

    // Scale the captured sample and clamp to what four digits can show.
    always_comb begin
        product = 32'(sample_q) * SCALE_MUL;
        scaled  = (product > BcdMax) ? BinW'(BcdMax) : product[BinW-1:0];
    end

    // FSM next-state; the period counter saturates so a late UPDATE just delays the next START.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        sample_d  = sample_q;
        bcd_d     = bcd_q;
        timeout_d = timeout_q;
        dab_start = 1'b0;
        period_d  = (period_q == PeriodW'(SAMPLE_PERIOD - 1)) ? period_q
                                                               : period_q + PeriodW'(1);
        unique case (state_q)
            StIdle: begin
                step_d = '0;
                if (period_q == PeriodW'(SAMPLE_PERIOD - 1)) begin
                    period_d = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (step_q == StepW'(WR_PULSE - 1)) begin
                    step_d  = '0;
                    state_d = StWait;
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            StWait: begin
                if (!intr_sync_q) begin
                    step_d  = '0;
                    state_d = StRead;
                end else if (step_q == StepW'(INTR_TIMEOUT - 1)) begin
                    step_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            StRead: begin
                if (step_q == StepW'(RD_PULSE - 1)) begin
                    step_d   = '0;
                    sample_d = adc_data;
                    state_d  = StScale;
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            StScale: begin
                dab_start = 1'b1;
                state_d   = StConv;
            end
            StConv: begin
                // Load the display word on the edge into UPDATE, while busy is still high.
                if (dab_done) begin
                    bcd_d     = pack_digits(dab_bcd);
                    timeout_d = 1'b0;
                    state_d   = StUpdate;
                end
            end
            StUpdate: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and datapath state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            period_q  <= '0;
            step_q    <= '0;
            sample_q  <= '0;
            bcd_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            step_q    <= step_d;
            sample_q  <= sample_d;
            bcd_q     <= bcd_d;
            timeout_q <= timeout_d;
        end
    end

    // Registered, glitch-free strobes decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cs_n_q  <= !(state_d inside {StStart, StWait, StRead});
            wr_n_q  <= (state_d != StStart);
            rd_n_q  <= (state_d != StRead);
            busy_q  <= (state_d inside {StRead, StScale, StConv, StUpdate});
            valid_q <= (state_d == StUpdate);
        end
    end

    bcd_dabble_seq u_dabble (
        .clk   (clk),
        .rst   (rst),
        .start (dab_start),
        .bin   (scaled),
        .done  (dab_done),
        .bcd   (dab_bcd)
    );

    assign adc_cs_n    = cs_n_q;
    assign adc_wr_n    = wr_n_q;
    assign adc_rd_n    = rd_n_q;
    assign bcd         = bcd_q;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_bcd_front.sv
// Bench for adc_bcd_front: ADC0804 behaviour model, randomized samples, arithmetic reference.
module tb_adc_bcd_front;

    localparam int unsigned SP  = 400;
    localparam int unsigned WR  = 8;
    localparam int unsigned RD  = 8;
    localparam int unsigned TO  = 200;
    // Raw intr_n edge to valid: two synchroniser stages plus RD + 1 + 14 + 1.
    localparam int unsigned LAT = RD + 1 + 14 + 1 + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  adc_data = 8'd0;
    logic        adc_intr_n = 1'b1;

    logic        a_cs_n, a_wr_n, a_rd_n, a_busy, a_valid, a_timeout_err;
    logic [15:0] a_bcd;
    logic        b_cs_n, b_wr_n, b_rd_n, b_busy, b_valid, b_timeout_err;
    logic [15:0] b_bcd;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] exp_a = 16'h0;
    logic [15:0] exp_b = 16'h0;

    adc_bcd_front #(
        .SAMPLE_PERIOD (SP), .WR_PULSE (WR), .RD_PULSE (RD), .INTR_TIMEOUT (TO), .SCALE_MUL (1)
    ) dut_a (
        .clk (clk), .rst (rst), .adc_data (adc_data), .adc_intr_n (adc_intr_n),
        .adc_cs_n (a_cs_n), .adc_wr_n (a_wr_n), .adc_rd_n (a_rd_n), .bcd (a_bcd),
        .busy (a_busy), .valid (a_valid), .timeout_err (a_timeout_err)
    );

    adc_bcd_front #(
        .SAMPLE_PERIOD (SP), .WR_PULSE (WR), .RD_PULSE (RD), .INTR_TIMEOUT (TO), .SCALE_MUL (40)
    ) dut_b (
        .clk (clk), .rst (rst), .adc_data (adc_data), .adc_intr_n (adc_intr_n),
        .adc_cs_n (b_cs_n), .adc_wr_n (b_wr_n), .adc_rd_n (b_rd_n), .bcd (b_bcd),
        .busy (b_busy), .valid (b_valid), .timeout_err (b_timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: value = min(data*mul, 9999), thousands in [3:0] .. units in [15:12].
    function automatic logic [15:0] ref_bcd(input int unsigned data, input int unsigned mul);
        int unsigned v;
        v = data * mul;
        if (v > 9999) v = 9999;
        return {4'(v % 10), 4'((v / 10) % 10), 4'((v / 100) % 10), 4'(v / 1000)};
    endfunction

    // Strobe-shape monitor: pulse widths, busy rising with RD, bcd only moving while busy.
    int          wr_low = 0;
    int          rd_low = 0;
    logic        prev_busy = 1'b0;
    logic        prev_rd = 1'b1;
    logic [15:0] prev_bcd = 16'h0;
    always @(negedge clk) begin
        if (!rst) begin
            wr_low = 0; rd_low = 0; prev_busy = 1'b0; prev_rd = 1'b1; prev_bcd = 16'h0;
        end else begin
            if (!a_wr_n) wr_low++;
            else if (wr_low != 0) begin check("wr_pulse_width", wr_low, WR); wr_low = 0; end
            if (!a_rd_n) rd_low++;
            else if (rd_low != 0) begin check("rd_pulse_width", rd_low, RD); rd_low = 0; end
            if (prev_rd && !a_rd_n) check("busy_rise_at_read", {prev_busy, a_busy}, 2'b01);
            if (a_bcd != prev_bcd) check("bcd_change_while_busy", a_busy, 1'b1);
            prev_busy = a_busy; prev_rd = a_rd_n; prev_bcd = a_bcd;
        end
    end

    task automatic wait_wr_cycle(output int rise_cyc, output bit ok);
        rise_cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < int'(SP) + 50; i++) begin
            @(negedge clk);
            if (!a_wr_n) begin ok = 1'b1; break; end
        end
        if (!ok) begin check("wr_fall_timeout", 0, 1); return; end
        ok = 1'b0;
        for (int i = 0; i < int'(WR) + 10; i++) begin
            @(negedge clk);
            if (a_wr_n) begin ok = 1'b1; break; end
        end
        if (!ok) begin check("wr_rise_timeout", 0, 1); return; end
        rise_cyc = cyc;
    endtask

    // One full conversion: ADC answers `delay` cycles after WR rises.
    task automatic do_conv(input logic [7:0] data, input int delay);
        int rise;
        int k;
        bit ok;
        wait_wr_cycle(rise, ok);
        if (!ok) return;
        repeat (delay) @(negedge clk);
        check("cs_low_in_wait", a_cs_n, 1'b0);
        adc_data = data;
        adc_intr_n = 1'b0;
        k = cyc;
        ok = 1'b0;
        for (int i = 0; i < int'(LAT) + 20; i++) begin
            @(negedge clk);
            if (!a_rd_n) adc_intr_n = 1'b1;
            if (a_valid) begin ok = 1'b1; break; end
        end
        adc_intr_n = 1'b1;
        if (!ok) begin check("valid_timeout", 0, 1); return; end
        exp_a = ref_bcd(data, 1);
        exp_b = ref_bcd(data, 40);
        check("latency", cyc - k, LAT);
        check("bcd_mul1", a_bcd, exp_a);
        check("bcd_mul40", b_bcd, exp_b);
        check("valid_mul40", b_valid, 1'b1);
        check("timeout_err_clear", a_timeout_err, 1'b0);
        @(negedge clk);
        check("valid_one_cycle", a_valid, 1'b0);
        check("busy_fall", a_busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, a_cs_n, 1'b1);
        check({tag, "_wr_n"}, a_wr_n, 1'b1);
        check({tag, "_rd_n"}, a_rd_n, 1'b1);
        check({tag, "_bcd"}, a_bcd, 16'h0);
        check({tag, "_busy"}, a_busy, 1'b0);
        check({tag, "_valid"}, a_valid, 1'b0);
        check({tag, "_terr"}, a_timeout_err, 1'b0);
        check({tag, "_b_strobes"}, {b_cs_n, b_wr_n, b_rd_n, b_busy}, 4'b1110);
        check({tag, "_b_bcd"}, b_bcd, 16'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rise;
        bit  ok;
        bit  found;
        bit  bad;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Directed handshake and boundary samples.
        do_conv(8'd37, 100);
        check("bcd_37", a_bcd, 16'h7300);
        do_conv(8'd0, 40);
        check("bcd_0", a_bcd, 16'h0000);
        do_conv(8'd255, 60);
        check("bcd_255", a_bcd, 16'h5520);
        check("bcd_255_clamp", b_bcd, 16'h9999);

        // ADC never answers: timeout after TO cycles of WAIT, bcd held.
        wait_wr_cycle(rise, ok);
        if (ok) begin
            found = 1'b0;
            for (int i = 0; i < int'(TO) + 20; i++) begin
                @(negedge clk);
                if (a_timeout_err) begin found = 1'b1; break; end
            end
            check("timeout_set", found, 1'b1);
            if (found) check("timeout_delay", cyc - rise, TO);
            check("timeout_bcd_hold", a_bcd, exp_a);
            check("timeout_cs_release", a_cs_n, 1'b1);
            check("timeout_set_mul40", b_timeout_err, 1'b1);
        end
        do_conv(8'($urandom_range(1, 254)), int'($urandom_range(1, 150)));

        // Spurious intr_n during IDLE must not start a read.
        bad = 1'b0;
        adc_intr_n = 1'b0;
        repeat (3) begin @(negedge clk); bad |= !a_rd_n || a_valid; end
        adc_intr_n = 1'b1;
        repeat (10) begin @(negedge clk); bad |= !a_rd_n || a_valid; end
        check("spurious_intr_ignored", bad, 1'b0);
        do_conv(8'($urandom_range(0, 255)), int'($urandom_range(1, 150)));

        // Reset in the middle of the conversion.
        wait_wr_cycle(rise, ok);
        if (ok) begin
            repeat (20) @(negedge clk);
            adc_data = 8'd99;
            adc_intr_n = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!a_rd_n) begin found = 1'b1; break; end
            end
            adc_intr_n = 1'b1;
            check("midconv_read_seen", found, 1'b1);
            for (int i = 0; i < 20 && !a_rd_n; i++) @(negedge clk);
            repeat (5) @(negedge clk);
            #2 rst = 1'b0;
            #1 check_reset_outputs("midconv_reset");
            repeat (3) @(negedge clk);
            rst = 1'b1;
            exp_a = 16'h0;
            exp_b = 16'h0;
        end
        do_conv(8'($urandom_range(0, 255)), int'($urandom_range(1, 150)));

        for (int n = 0; n < 6; n++) begin
            do_conv(8'($urandom_range(0, 255)), int'($urandom_range(1, 150)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
